// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave.
// Imported by the top and its synchronizer.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input.
// Reset value is the idle level of the line it samples.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// Mode-0, MSB-first SPI slave clocked entirely by clk.
// sclk, chip_select and mosi are oversampled through synchronizers.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W        = SPI_DATA_W,
    parameter int CLK_RATIO_MIN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              chip_select,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_state_t state, state_nxt;

    logic [DATA_W-1:0] rx_shift, tx_shift, hold;
    logic [CNT_W-1:0]  bit_cnt;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .d(chip_select), .q(cs_s)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign miso = ~cs_s & tx_shift[DATA_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (cs_fall) state_nxt = LOAD;
            LOAD:  state_nxt = cs_rise ? IDLE : SHIFT;
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else if (bit_cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:  state_nxt = cs_s ? IDLE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            bit_cnt     <= '0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (tx_load && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
            unique case (state)
                LOAD: begin
                    if (!cs_rise) begin
                        if (!tx_ready) begin
                            tx_shift <= hold;
                            tx_ready <= 1'b1;
                        end else begin
                            tx_shift    <= '0;
                            tx_underrun <= 1'b1;
                        end
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!cs_rise) begin
                        if (sclk_rise && bit_cnt != CNT_LAST) begin
                            rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        // A fall before the first rise is the tail of the
                        // previous frame and must not eat the new MSB.
                        if (sclk_fall && bit_cnt != '0) begin
                            tx_shift <= tx_shift << 1;
                        end
                    end
                end
                DONE: begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single frames plus
// hand sequences for back-to-back, abort, tx_load races and reset.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       chip_select;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;

    spi_slave dut (
        .clk(clk),
        .reset(reset),
        .sclk(sclk),
        .chip_select(chip_select),
        .mosi(mosi),
        .miso(miso),
        .tx_data(tx_data),
        .tx_load(tx_load),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_rise_cyc = 0;
    int rx_cyc  = 0;
    int und_cnt = 0;
    int und_at_valid = 0;
    logic [7:0] rx_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log.push_back(rx_data);
            rx_cyc       = cyc;
            und_at_valid = und_cnt;
        end
        if (tx_underrun) und_cnt = und_cnt + 1;
    end

    typedef struct {
        logic [7:0] mo;
        logic [7:0] tx;
        bit         pre;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs[5];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic frame(input logic [7:0] mo, input int nbits,
                         input bit ld_en, input logic [7:0] ld,
                         output logic [7:0] mi);
        mi = '0;
        for (int k = 0; k < nbits; k++) begin
            int i;
            i = 7 - k;
            mosi = mo[i];
            if (ld_en && i == 4) begin
                tick(4);
                tx_data = ld;
                tx_load = 1'b1;
                tick(1);
                tx_load = 1'b0;
            end else begin
                tick(5);
            end
            mi[i] = miso;
            if (i == 0) last_rise_cyc = cyc;
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
    endtask

    logic [7:0] mi, mi2;
    int n0, u0;

    initial begin
        reset = 1'b0; chip_select = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_load = 1'b0; tx_data = '0;

        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C, 0};
        vecs[1] = '{8'h0F, 8'h00, 1'b0, 8'h0F, 8'h00, 1};
        vecs[2] = '{8'hC3, 8'h96, 1'b1, 8'hC3, 8'h96, 0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 0};
        vecs[4] = '{8'hFF, 8'h01, 1'b1, 8'hFF, 8'h01, 0};

        tick(2);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_underrun", 32'(tx_underrun), 32'd0);
        reset = 1'b1;
        tick(3);

        foreach (vecs[v]) begin
            if (vecs[v].pre) load_tx(vecs[v].tx);
            n0 = rx_log.size();
            u0 = und_cnt;
            chip_select = 1'b0;
            tick(10);
            frame(vecs[v].mo, 8, 1'b0, 8'h00, mi);
            tick(3);
            chip_select = 1'b1;
            tick(10);
            chk($sformatf("v%0d_nvalid", v), 32'(rx_log.size() - n0), 32'd1);
            chk($sformatf("v%0d_rx", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            chk($sformatf("v%0d_miso", v), 32'(mi), 32'(vecs[v].exp_miso));
            chk($sformatf("v%0d_underrun", v), 32'(und_at_valid - u0),
                32'(vecs[v].exp_und));
            chk($sformatf("v%0d_latency", v), 32'(rx_cyc - last_rise_cyc),
                32'd5);
        end

        // second load while holding register full is ignored
        load_tx(8'h55);
        chk("dbl_ready_lo", 32'(tx_ready), 32'd0);
        load_tx(8'h66);
        chip_select = 1'b0;
        tick(10);
        frame(8'h12, 8, 1'b0, 8'h00, mi);
        tick(3);
        chip_select = 1'b1;
        tick(10);
        chk("dbl_miso", 32'(mi), 32'h55);
        chk("dbl_rx", 32'(rx_data), 32'h12);

        // tx_load in the same cycle LOAD consumes the holding register
        load_tx(8'hE7);
        chip_select = 1'b0;
        tick(3);
        tx_data = 8'h99;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        chk("race_ready", 32'(tx_ready), 32'd1);
        tick(6);
        frame(8'h3C, 8, 1'b0, 8'h00, mi);
        tick(3);
        chip_select = 1'b1;
        tick(10);
        chk("race_miso", 32'(mi), 32'hE7);
        chk("race_rx", 32'(rx_data), 32'h3C);

        // back-to-back frames, second byte loaded mid-frame
        load_tx(8'h11);
        n0 = rx_log.size();
        u0 = und_cnt;
        chip_select = 1'b0;
        tick(10);
        frame(8'h81, 8, 1'b1, 8'h22, mi);
        frame(8'h7E, 8, 1'b0, 8'h00, mi2);
        tick(3);
        chip_select = 1'b1;
        tick(10);
        chk("b2b_nvalid", 32'(rx_log.size() - n0), 32'd2);
        if (rx_log.size() - n0 == 2) begin
            chk("b2b_rx0", 32'(rx_log[n0]), 32'h81);
            chk("b2b_rx1", 32'(rx_log[n0+1]), 32'h7E);
        end
        chk("b2b_miso0", 32'(mi), 32'h11);
        chk("b2b_miso1", 32'(mi2), 32'h22);
        chk("b2b_underrun", 32'(und_at_valid - u0), 32'd0);

        // abort after four bits
        n0 = rx_log.size();
        chk("abort_ready_pre", 32'(tx_ready), 32'd1);
        chip_select = 1'b0;
        tick(10);
        frame(8'hFF, 4, 1'b0, 8'h00, mi);
        chip_select = 1'b1;
        tick(10);
        chk("abort_nvalid", 32'(rx_log.size() - n0), 32'd0);
        chk("abort_rx_kept", 32'(rx_data), 32'h7E);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_miso", 32'(miso), 32'd0);

        // reset mid-frame
        chip_select = 1'b0;
        tick(10);
        load_tx(8'h5A);
        frame(8'hFF, 3, 1'b0, 8'h00, mi);
        sclk = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("mrst_rx_data", 32'(rx_data), 32'h00);
        chk("mrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("mrst_underrun", 32'(tx_underrun), 32'd0);
        chk("mrst_ready", 32'(tx_ready), 32'd1);
        chk("mrst_miso", 32'(miso), 32'd0);
        sclk = 1'b0;
        chip_select = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(10);
        n0 = rx_log.size();
        chip_select = 1'b0;
        tick(10);
        frame(8'hC3, 8, 1'b0, 8'h00, mi);
        tick(3);
        chip_select = 1'b1;
        tick(10);
        chk("mrst_nvalid", 32'(rx_log.size() - n0), 32'd1);
        chk("mrst_rx", 32'(rx_data), 32'hC3);
        chk("mrst_miso_frame", 32'(mi), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
